// File: rtl/ifetch32_sync_if.sv
`default_nettype none
// ============================================================================
// Module   : ifetch32_sync_if
// Purpose  : Program-ROM bus between the fetch stage and a synchronous ROM.
// Revision : 1.0 - initial release
// ============================================================================
interface ifetch32_sync_if #(
  parameter int unsigned ROM_ADDR_W = 14
);
  logic [ROM_ADDR_W-1:0] rom_addr;
  logic [31:0]           rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface
`default_nettype wire

// File: rtl/ifetch32_sync.sv
`default_nettype none
// ============================================================================
// Module   : ifetch32_sync
// Purpose  : MIPS-subset fetch stage: PC, next-PC select, JAL link, retire count.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch32_sync #(
  parameter int unsigned ROM_ADDR_W = 14,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                   clock,
  input  logic                   reset,
  ifetch32_sync_if.master        rom,
  input  logic                   stall,
  input  logic                   Branch,
  input  logic                   nBranch,
  input  logic                   Jmp,
  input  logic                   Jal,
  input  logic                   Jrn,
  input  logic                   Zero,
  input  logic [31:0]            Addr_result,
  input  logic [31:0]            Read_data_1,
  output logic [31:0]            Instruction,
  output logic [5:0]             Opcode,
  output logic [5:0]             Function_opcode,
  output logic                   inst_valid,
  output logic [31:0]            PC,
  output logic [31:0]            PC_plus_4,
  output logic [31:0]            opcplus4,
  output logic [31:0]            inst_count,
  output logic                   misalign
);

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] link_q;
  logic [31:0] count_q;
  logic        misalign_q;
  logic        retire;
  logic [31:0] pc_plus_4;
  logic        br_taken;

  assign pc_plus_4 = pc_q + 32'd4;
  assign br_taken  = (Branch & Zero) | (nBranch & ~Zero);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    retire  = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = RUN;
        pc_d    = RESET_PC;
        valid_d = 1'b1;
      end
      RUN: begin
        if (!stall) begin
          pc_d = pc_plus_4;
          if (valid_q) begin
            retire = 1'b1;
            if (Jrn)
              pc_d = {Read_data_1[31:2], 2'b00};
            else if (Jmp || Jal)
              pc_d = {pc_plus_4[31:28], Instruction[25:0], 2'b00};
            else if (br_taken)
              pc_d = Addr_result;
          end
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      link_q     <= 32'h0;
      count_q    <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      if (retire) begin
        count_q <= count_q + 32'd1;
        if (Jal)
          link_q <= pc_plus_4;
        if (Jrn && (Read_data_1[1:0] != 2'b00))
          misalign_q <= 1'b1;
      end
    end
  end

  // The synchronous ROM output register doubles as the instruction register:
  // it is addressed with next-PC, so it always holds the word at PC.
  // Gating with valid discards stale or in-flight reads around reset.
  assign rom.rom_addr    = pc_d[ROM_ADDR_W+1:2];
  assign Instruction     = valid_q ? rom.rom_data : 32'h0;
  assign Opcode          = Instruction[31:26];
  assign Function_opcode = Instruction[5:0];
  assign inst_valid      = valid_q;
  assign PC              = pc_q;
  assign PC_plus_4       = pc_plus_4;
  assign opcplus4        = link_q;
  assign inst_count      = count_q;
  assign misalign        = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_ifetch32_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch32_sync
// Purpose  : Directed self-checking bench for ifetch32_sync with a ROM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch32_sync;

  localparam int unsigned C_AW = 14;

  logic        clock;
  logic        reset;
  logic        stall, Branch, nBranch, Jmp, Jal, Jrn, Zero;
  logic [31:0] Addr_result, Read_data_1;
  logic [31:0] Instruction, PC, PC_plus_4, opcplus4, inst_count;
  logic [5:0]  Opcode, Function_opcode;
  logic        inst_valid, misalign;

  int          n_chk;
  int          n_fail;
  logic [31:0] exp_cnt;
  logic [31:0] rom_mem [0:1023];

  ifetch32_sync_if #(.ROM_ADDR_W(C_AW)) rif ();

  ifetch32_sync #(.ROM_ADDR_W(C_AW), .RESET_PC(32'h0000_0000)) dut (
    .clock          (clock),
    .reset          (reset),
    .rom            (rif),
    .stall          (stall),
    .Branch         (Branch),
    .nBranch        (nBranch),
    .Jmp            (Jmp),
    .Jal            (Jal),
    .Jrn            (Jrn),
    .Zero           (Zero),
    .Addr_result    (Addr_result),
    .Read_data_1    (Read_data_1),
    .Instruction    (Instruction),
    .Opcode         (Opcode),
    .Function_opcode(Function_opcode),
    .inst_valid     (inst_valid),
    .PC             (PC),
    .PC_plus_4      (PC_plus_4),
    .opcplus4       (opcplus4),
    .inst_count     (inst_count),
    .misalign       (misalign)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) rif.rom_data <= rom_mem[rif.rom_addr[9:0]];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  task automatic step(input logic ret);
    @(posedge clock);
    #1;
    if (ret) exp_cnt = exp_cnt + 32'd1;
  endtask

  task automatic clr_ctl();
    Branch = 0; nBranch = 0; Jmp = 0; Jal = 0; Jrn = 0; Zero = 0;
    Addr_result = 32'h0; Read_data_1 = 32'h0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; exp_cnt = 32'h0;
    reset = 1'b0; stall = 1'b0;
    clr_ctl();
    for (int i = 0; i < 1024; i++) rom_mem[i] = 32'h2000_0000 | 32'(i);
    rom_mem[0]  = 32'h0022_1820;   // add  $3,$1,$2
    rom_mem[1]  = 32'h2021_0001;   // addi $1,$1,1
    rom_mem[2]  = 32'h8C22_0000;   // lw   $2,0($1)
    rom_mem[3]  = 32'hAC23_0004;   // sw   $3,4($1)
    rom_mem[4]  = 32'h0C00_0040;   // jal  0x100
    rom_mem[64] = 32'h0022_1820;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_pc",    PC, 32'h0);
    chk("rst_pc4",   PC_plus_4, 32'h4);
    chk("rst_instr", Instruction, 32'h0);
    chk("rst_op",    {26'h0, Opcode}, 32'h0);
    chk("rst_fn",    {26'h0, Function_opcode}, 32'h0);
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_link",  opcplus4, 32'h0);
    chk("rst_cnt",   inst_count, 32'h0);
    chk("rst_mis",   {31'h0, misalign}, 32'h0);
    chk("rst_raddr", {18'h0, rif.rom_addr}, 32'h0);

    @(negedge clock) reset = 1'b1;
    step(1'b0);
    chk("boot_valid", {31'h0, inst_valid}, 32'h1);
    chk("boot_pc",    PC, 32'h0);
    chk("boot_op",    {26'h0, Opcode}, 32'h0);
    chk("boot_fn",    {26'h0, Function_opcode}, 32'h20);
    chk("boot_cnt",   inst_count, exp_cnt);

    repeat (3) step(1'b1);
    chk("seq_pc",    PC, 32'd12);
    chk("seq_cnt",   inst_count, 32'd3);
    chk("seq_instr", Instruction, 32'hAC23_0004);

    step(1'b1);
    chk("jal_pc",    PC, 32'h10);
    chk("jal_instr", Instruction, 32'h0C00_0040);
    Jal = 1'b1;
    step(1'b1);
    Jal = 1'b0;
    chk("jal_tgt",   PC, 32'h100);
    chk("jal_link",  opcplus4, 32'h14);
    chk("jal_instr2", Instruction, 32'h0022_1820);

    Branch = 1; Zero = 1; Addr_result = 32'h40;
    step(1'b1);
    chk("beq_taken", PC, 32'h40);
    Zero = 0;
    step(1'b1);
    chk("beq_fall",  PC, 32'h44);
    Branch = 0; nBranch = 1; Zero = 0;
    step(1'b1);
    chk("bne_taken", PC, 32'h40);
    Branch = 1; nBranch = 1; Zero = 0; Addr_result = 32'h80;
    step(1'b1);
    chk("both_taken", PC, 32'h80);
    Branch = 0; nBranch = 1; Zero = 1;
    step(1'b1);
    chk("bne_fall",  PC, 32'h84);
    chk("cnt_mid",   inst_count, exp_cnt);
    clr_ctl();

    Jrn = 1; Jmp = 1; Read_data_1 = 32'h0000_0203;
    step(1'b1);
    chk("jr_mis_pc", PC, 32'h200);
    chk("jr_mis",    {31'h0, misalign}, 32'h1);
    chk("jr_instr",  Instruction, rom_mem[128]);
    Read_data_1 = 32'h200;
    step(1'b1);
    chk("jr_win_pc", PC, 32'h200);
    clr_ctl();
    step(1'b1);
    chk("jr_next",   PC, 32'h204);
    chk("mis_sticky", {31'h0, misalign}, 32'h1);
    chk("link_hold", opcplus4, 32'h14);

    stall = 1'b1;
    Jmp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      chk("stl_pc",    PC, 32'h204);
      chk("stl_instr", Instruction, rom_mem[129]);
      chk("stl_cnt",   inst_count, exp_cnt);
    end
    stall = 1'b0;
    Jmp = 1'b0;
    step(1'b1);
    chk("rel_pc",    PC, 32'h208);
    chk("rel_instr", Instruction, rom_mem[130]);
    chk("rel_cnt",   inst_count, exp_cnt);

    Jrn = 1; Read_data_1 = 32'h80;
    step(1'b1);
    clr_ctl();
    chk("pre_rst_pc", PC, 32'h80);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_pc",    PC, 32'h0);
    chk("arst_valid", {31'h0, inst_valid}, 32'h0);
    chk("arst_instr", Instruction, 32'h0);
    chk("arst_cnt",   inst_count, 32'h0);
    chk("arst_mis",   {31'h0, misalign}, 32'h0);
    chk("arst_link",  opcplus4, 32'h0);
    chk("arst_raddr", {18'h0, rif.rom_addr}, 32'h0);
    exp_cnt = 32'h0;

    @(negedge clock) reset = 1'b1;
    step(1'b0);
    chk("reboot_pc",    PC, 32'h0);
    chk("reboot_instr", Instruction, 32'h0022_1820);

    @(negedge clock);
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    #1;
    chk("wrap_pre", inst_count, 32'hFFFF_FFFF);
    step(1'b0);
    chk("wrap_cnt", inst_count, 32'h0);
    chk("wrap_pc",  PC, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
